// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter sharing one decoder among N requesters; a grant is held
// until the owner is done, drops its request, or reaches the MAX_HOLD limit.
module rr_decode_arbiter #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   done,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_en,
  output logic           timeout
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           timeout_q, timeout_d;
  logic [N-1:0]   grant_q, grant_d;

  logic           found;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic           ownerDone, ownerReq, atLimit;

  // Scan from the priority pointer upward; IDW-bit addition wraps mod N for free.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr_q + IDW'(i);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign ownerDone = done[id_q];
  assign ownerReq  = req[id_q];
  assign atLimit   = (cnt_q == HOLD_LIMIT);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    grant_d   = grant_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          id_d    = winner;
          cnt_d   = 8'd1;
          grant_d = {{(N-1){1'b0}}, 1'b1} << winner;
        end
      end
      BUSY: begin
        if (ownerDone || !ownerReq || atLimit) begin
          state_d   = IDLE;
          grant_d   = '0;
          cnt_d     = 8'd0;
          ptr_d     = id_q + IDW'(1);
          // A timeout is only reported when the limit alone forced the release.
          timeout_d = atLimit && !ownerDone && ownerReq;
        end else if (cnt_q < HOLD_LIMIT) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      grant_q   <= grant_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = id_q;
  assign grant_en = (state_q == BUSY);
  assign timeout  = timeout_q;

endmodule
